alu_writeback_stage: RTL
========================

# alu_writeback_stage

Registered pipeline stage directly downstream of the ALU result multiplexer. Each accepted ALU result is captured together with its destination register and computed N/Z/C/V flags. The result is presented to the register-file write port through a valid/ready handshake with full throughput. An architectural status-flag register and a sticky illegal-opcode indicator are kept. A two-entry skid buffer isolates a stalling consumer from the ALU without a combinational ready path.

## Interface
Parameters:
- N, 8, datapath width (result and write-back data)
- RA, 4, register-address width

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- alu_y  input  N  selected ALU result (output of the result mux)
- alu_sel  input  4  operation selector that produced alu_y (same encoding as the mux: 0 add, 1 sub, 2 and, 3 or, 4 nor, 5 xor, 6 lsl, 7 lsr, 8 asr)
- carry_in  input  1  adder/subtractor carry-out for this result
- overflow_in  input  1  adder/subtractor signed overflow for this result
- rd_in  input  RA  destination register address
- in_valid  input  1  upstream presents a result this cycle
- in_ready  output  1  stage can accept; registered, no combinational path from out_ready
- wb_data  output  N  write-back data
- wb_rd  output  RA  write-back register address
- wb_en  output  1  write-back enable (0 for illegal opcode entries)
- out_valid  output  1  wb_* outputs hold a valid entry
- out_ready  input  1  register file consumes the entry this cycle
- status_flags  output  4  {N,Z,C,V} architectural status register
- illegal_op  output  1  sticky: an entry with alu_sel > 8 has been retired

## Operation
- Input transfer: in_valid && in_ready. Output transfer: out_valid && out_ready.
- Entry contents are computed at the input transfer and stored: data, rd, wb_en, nf, zf, cf, vf, cv_upd, illegal.
  - nf = alu_y[N-1]; zf = (alu_y == 0).
  - For alu_sel 0 or 1: cf = carry_in, vf = overflow_in, cv_upd = 1.
  - For alu_sel 2..8: cv_upd = 0; C and V in the status register are held.
  - For alu_sel 9..15: illegal = 1, wb_en = 0, data = 0.
- Storage is a main register M and a skid register S.
  - M drives the outputs; out_valid = M.valid.
  - in_ready = !S.valid.
- An input transfer goes into M if M is empty or an output transfer occurs that cycle. Otherwise it goes into S.
- After an output transfer, if S is valid, S moves to M and S is cleared the same edge. An input transfer in that cycle cannot occur, because in_ready = 0.
- Retire, on an output transfer of entry E:
  - If E.wb_en: status N,Z ← E.nf,E.zf.
  - If E.wb_en and E.cv_upd: status C,V ← E.cf,E.vf.
  - If E.illegal: illegal_op ← 1, and the status register is unchanged.
- Ordering: entries retire strictly in acceptance order; none is dropped or duplicated.

## Timing
- Reset (asynchronous, any cycle, including mid-stall): M.valid = S.valid = 0, out_valid = 0, in_ready = 1 from the first edge after deassertion, wb_data = 0, wb_rd = 0, wb_en = 0, status_flags = 4'b0000, illegal_op = 0. In-flight entries are discarded.
- Latency: input transfer at edge k gives out_valid = 1 with that entry after edge k.
- Throughput: one entry per cycle while out_ready = 1.
- Stall: with out_ready = 0, at most two entries are accepted. in_ready falls the cycle after S fills.
- Resume: S reaches the outputs one cycle after M retires. in_ready rises the cycle after S drains.
- status_flags and illegal_op change on the edge of the retiring output transfer and are visible the following cycle.
- wb_* hold stable while out_valid && !out_ready.

## Structure
- Shared package alu_pkg:
  - alu_op_t enum, codes 0..8, shared with the result mux and the decoder.
  - ALU_OP_LAST = 8.
  - flags_t packed struct {n,z,c,v}.
- Entry type wb_entry_t, parameterized by N and RA, is local to this module.
- One natural sub-module: alu_skid_buffer (generic two-entry valid/ready buffer of a packed payload).
  - The top level adds flag computation, the retire logic, the status register and the illegal_op register.

## Test plan
- Add overflow, N=8, consumer always ready: alu_sel=0, alu_y=0x80, carry_in=0, overflow_in=1, rd=3 → next cycle: wb_data=0x80, wb_rd=3, wb_en=1. After retire: status_flags=1001.
- Logic op preserves C/V: after the previous case, retire alu_sel=2, alu_y=0x00 → status_flags=0101. V stays 1; C stays 0.
- Backpressure: out_ready=0, present 0x11, 0x22, 0x33 on consecutive cycles → only 0x11 and 0x22 are accepted. in_ready=0 from the third cycle. Raising out_ready retires 0x11 then 0x22 on consecutive cycles, then 0x33 is accepted.
- Illegal selector: alu_sel=12, alu_y=0x00 → wb_en=0 at the output. After retire: illegal_op=1 and status_flags unchanged. illegal_op stays 1 through later legal retires.
- Asynchronous reset while S is full: out_valid=0, in_ready=1, status_flags=0000, illegal_op=0 immediately. No stale entry appears afterwards.
- Streaming 100 random entries with random out_ready: wb_data/wb_rd sequence equals the input sequence. status_flags match a reference model after every retire.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes used by the result mux and decoder,
// the status-flag layout, and the state encoding of the write-back skid buffer.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_NOR = 4'd4,
    ALU_XOR = 4'd5,
    ALU_LSL = 4'd6,
    ALU_LSR = 4'd7,
    ALU_ASR = 4'd8
  } alu_op_t;

  localparam logic [3:0] ALU_OP_LAST = 4'd8;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  typedef enum logic [1:0] {
    SKID_EMPTY,
    SKID_ONE,
    SKID_TWO
  } skid_state_t;

  function automatic logic is_illegal_op(input logic [3:0] sel);
    return sel > ALU_OP_LAST;
  endfunction

  function automatic logic updates_cv(input logic [3:0] sel);
    return (alu_op_t'(sel) == ALU_ADD) || (alu_op_t'(sel) == ALU_SUB);
  endfunction

endpackage

// File: rtl/alu_writeback_stage_if.sv
// Handshake bundle between the ALU result mux, the write-back stage and the
// register-file write port. The stage uses the slave view; its environment the master view.
interface alu_writeback_stage_if #(
  parameter int N  = 8,
  parameter int RA = 4
);

  logic [N-1:0]  alu_y;
  logic [3:0]    alu_sel;
  logic          carry_in;
  logic          overflow_in;
  logic [RA-1:0] rd_in;
  logic          in_valid;
  logic          in_ready;

  logic [N-1:0]  wb_data;
  logic [RA-1:0] wb_rd;
  logic          wb_en;
  logic          out_valid;
  logic          out_ready;

  modport slave (
    input  alu_y, alu_sel, carry_in, overflow_in, rd_in, in_valid, out_ready,
    output in_ready, wb_data, wb_rd, wb_en, out_valid
  );

  modport master (
    output alu_y, alu_sel, carry_in, overflow_in, rd_in, in_valid, out_ready,
    input  in_ready, wb_data, wb_rd, wb_en, out_valid
  );

endinterface

// File: rtl/alu_skid_buffer.sv
// Two-entry valid/ready buffer for an opaque payload. M drives the outputs, S catches
// the one entry accepted while M stalls; in_ready decodes registered state only.
module alu_skid_buffer
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready
);

  skid_state_t  state_q, state_d;
  logic [W-1:0] m_q, m_d;
  logic [W-1:0] s_q, s_d;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and infers a latch.
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    unique case (state_q)
      SKID_EMPTY: begin
        if (in_valid) begin
          m_d     = in_data;
          state_d = SKID_ONE;
        end
      end
      SKID_ONE: begin
        if (in_valid && out_ready) begin
          m_d = in_data;
        end else if (in_valid) begin
          s_d     = in_data;
          state_d = SKID_TWO;
        end else if (out_ready) begin
          state_d = SKID_EMPTY;
        end
      end
      SKID_TWO: begin
        if (out_ready) begin
          m_d     = s_q;
          state_d = SKID_ONE;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q <= SKID_EMPTY;
      m_q     <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
    end
  end

  // NOTE: S holds data only; it is read solely while state_q says it is occupied, so it needs no reset.
  always_ff @(posedge clk) begin
    s_q <= s_d;
  end

  assign in_ready  = (state_q != SKID_TWO);
  assign out_valid = (state_q != SKID_EMPTY);
  assign out_data  = m_q;

endmodule

// File: rtl/alu_writeback_stage.sv
// Registered write-back stage after the ALU result mux: captures result, destination
// and flags, buffers them through a skid buffer, and updates status flags on retire.
module alu_writeback_stage
  import alu_pkg::*;
#(
  parameter int N  = 8,
  parameter int RA = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  alu_writeback_stage_if.slave  bus,
  output logic [3:0]            status_flags,
  output logic                  illegal_op
);

  typedef struct packed {
    logic [N-1:0]  data;
    logic [RA-1:0] rd;
    logic          wb_en;
    flags_t        flags;
    logic          cv_upd;
    logic          illegal;
  } wb_entry_t;

  wb_entry_t entry_in;
  wb_entry_t entry_m;
  logic      m_valid;
  logic      retire;

  flags_t flags_q, flags_d;
  logic   illegal_q, illegal_d;

  always_comb begin
    entry_in.illegal = is_illegal_op(bus.alu_sel);
    entry_in.cv_upd  = updates_cv(bus.alu_sel);
    entry_in.data    = entry_in.illegal ? '0 : bus.alu_y;
    entry_in.rd      = bus.rd_in;
    entry_in.wb_en   = !entry_in.illegal;
    entry_in.flags.n = bus.alu_y[N-1];
    entry_in.flags.z = (bus.alu_y == '0);
    entry_in.flags.c = entry_in.cv_upd & bus.carry_in;
    entry_in.flags.v = entry_in.cv_upd & bus.overflow_in;
  end

  alu_skid_buffer #(
    .W ($bits(wb_entry_t))
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (bus.in_valid),
    .in_data   (entry_in),
    .in_ready  (bus.in_ready),
    .out_valid (m_valid),
    .out_data  (entry_m),
    .out_ready (bus.out_ready)
  );

  assign retire = m_valid && bus.out_ready;

  // Illegal entries never touch the status register; they only set the sticky bit.
  always_comb begin
    flags_d   = flags_q;
    illegal_d = illegal_q;
    if (retire) begin
      if (entry_m.illegal) begin
        illegal_d = 1'b1;
      end else if (entry_m.wb_en) begin
        flags_d.n = entry_m.flags.n;
        flags_d.z = entry_m.flags.z;
        if (entry_m.cv_upd) begin
          flags_d.c = entry_m.flags.c;
          flags_d.v = entry_m.flags.v;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      flags_q   <= flags_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.out_valid = m_valid;
  assign bus.wb_data   = entry_m.data;
  assign bus.wb_rd     = entry_m.rd;
  assign bus.wb_en     = entry_m.wb_en & m_valid;
  assign status_flags  = flags_q;
  assign illegal_op    = illegal_q;

endmodule
